rst_seq: RTL

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 15 +
 rtl/rst_seq_sync2.sv | 26 ++
 rtl/rst_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding and
// the positions of the non-request cause bits above the request sources.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    // Offsets added to NUM_SRC to locate the clock-loss and power-on cause bits.
    localparam int CAUSE_CLK = 0;
    localparam int CAUSE_POR = 1;

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; both flops load a
// configurable inactive value while reset is asserted.
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all domains in reset while any source requests it,
// then releases the domains one by one in index order on a prescaled tick.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int NUM_OUT       = 3,
    parameter int HOLD_TICKS    = 24'hFFFFFF,
    parameter int STAGGER_TICKS = 16,
    parameter int CLK_DIV       = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               clk_ok,
    input  logic [NUM_SRC-1:0] rst_req,
    input  logic               cause_clr,
    output logic [NUM_OUT-1:0] rst_out,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic [NUM_SRC+1:0] rst_cause,
    output logic               busy
);

    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int STG_W  = (STAGGER_TICKS > 1) ? $clog2(STAGGER_TICKS) : 1;
    localparam int IDX_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'((STAGGER_TICKS > 0) ? STAGGER_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_OUT - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam bit                DIRECT_RUN = (NUM_OUT == 1) || (STAGGER_TICKS == 0);

    // Mask with every domain at or above index 'first' still held in reset.
    function automatic logic [NUM_OUT-1:0] keep_from(input int first);
        logic [NUM_OUT-1:0] m;
        for (int k = 0; k < NUM_OUT; k++) begin
            m[k] = (k >= first);
        end
        return m;
    endfunction

    logic [NUM_SRC-1:0] req_sync_s;
    logic               clk_ok_sync_s;
    logic               request_s;
    logic               tick_s;
    logic [NUM_OUT-1:0] release_mask_s;
    logic [NUM_SRC+1:0] cause_set_s;

    logic [DIV_W-1:0]   div_cnt_r;
    state_t             state_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [STG_W-1:0]   stg_cnt_r;
    logic [IDX_W-1:0]   idx_r;

    sync2 #(
        .WIDTH   (NUM_SRC),
        .RST_VAL ({NUM_SRC{1'b0}})
    ) u_req_sync (
        .clk (clk_in),
        .rst (rst_in),
        .d   (rst_req),
        .q   (req_sync_s)
    );

    // clk_ok idles high, so its synchroniser resets to the "clock good" level.
    sync2 #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_clk_sync (
        .clk (clk_in),
        .rst (rst_in),
        .d   (clk_ok),
        .q   (clk_ok_sync_s)
    );

    assign request_s      = (|req_sync_s) | ~clk_ok_sync_s;
    assign tick_s         = (div_cnt_r == DIV_LAST);
    assign release_mask_s = keep_from(int'(idx_r) + 1);

    // Free-running tick prescaler; requests never disturb its phase.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Sequencing FSM; a request in any state reasserts every domain at once.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= {HOLD_W{1'b0}};
            stg_cnt_r  <= {STG_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            rst_out    <= {NUM_OUT{1'b1}};
            rst_out_n  <= {NUM_OUT{1'b0}};
            busy       <= 1'b1;
        end else if (request_s) begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= {HOLD_W{1'b0}};
            stg_cnt_r  <= {STG_W{1'b0}};
            idx_r      <= {IDX_W{1'b0}};
            rst_out    <= {NUM_OUT{1'b1}};
            rst_out_n  <= {NUM_OUT{1'b0}};
            busy       <= 1'b1;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (tick_s) begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            hold_cnt_r <= {HOLD_W{1'b0}};
                            stg_cnt_r  <= {STG_W{1'b0}};
                            idx_r      <= IDX_W'(1);
                            if (DIRECT_RUN) begin
                                state_r   <= ST_RUN;
                                rst_out   <= {NUM_OUT{1'b0}};
                                rst_out_n <= {NUM_OUT{1'b1}};
                                busy      <= 1'b0;
                            end else begin
                                state_r   <= ST_STAGGER;
                                rst_out   <= keep_from(1);
                                rst_out_n <= ~keep_from(1);
                                busy      <= 1'b1;
                            end
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                        end
                    end
                end
                ST_STAGGER: begin
                    if (tick_s) begin
                        if (stg_cnt_r == STG_LAST) begin
                            stg_cnt_r <= {STG_W{1'b0}};
                            rst_out   <= release_mask_s;
                            rst_out_n <= ~release_mask_s;
                            if (idx_r == IDX_LAST) begin
                                state_r <= ST_RUN;
                                busy    <= 1'b0;
                            end else begin
                                idx_r   <= idx_r + IDX_W'(1);
                            end
                        end else begin
                            stg_cnt_r <= stg_cnt_r + STG_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    rst_out   <= {NUM_OUT{1'b0}};
                    rst_out_n <= {NUM_OUT{1'b1}};
                    busy      <= 1'b0;
                end
                default: begin
                    state_r    <= ST_HOLD;
                    hold_cnt_r <= {HOLD_W{1'b0}};
                    rst_out    <= {NUM_OUT{1'b1}};
                    rst_out_n  <= {NUM_OUT{1'b0}};
                    busy       <= 1'b1;
                end
            endcase
        end
    end

    // Per-cycle cause contributions from the synchronised sources.
    always_comb begin
        cause_set_s                       = {(NUM_SRC + 2){1'b0}};
        cause_set_s[NUM_SRC-1:0]          = req_sync_s;
        cause_set_s[NUM_SRC + CAUSE_CLK]  = ~clk_ok_sync_s;
    end

    // Sticky cause register; a set in the same cycle overrides the clear.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rst_cause                        <= {(NUM_SRC + 2){1'b0}};
            rst_cause[NUM_SRC + CAUSE_POR]   <= 1'b1;
        end else begin
            rst_cause <= (cause_clr ? {(NUM_SRC + 2){1'b0}} : rst_cause) | cause_set_s;
        end
    end

endmodule
